// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the Tuse/Tnew hazard scoreboard.
// The decoder uses the TUSE_*/TNEW_* encodings to pre-decode operands.
package hazard_scoreboard_pkg;

    localparam int HZ_REG_AW = 5;
    localparam int HZ_TW     = 3;

    // Bypass select value meaning "take the register file / pipe value".
    localparam int SEL_GRF = 0;

    // Tuse: cycles from D until the operand is consumed.
    localparam logic [HZ_TW-1:0] TUSE_D = 3'd0;
    localparam logic [HZ_TW-1:0] TUSE_E = 3'd1;
    localparam logic [HZ_TW-1:0] TUSE_M = 3'd2;

    // Tnew: cycles after entering E until the result exists.
    localparam logic [HZ_TW-1:0] TNEW_NONE = 3'd0;
    localparam logic [HZ_TW-1:0] TNEW_ALU  = 3'd1;
    localparam logic [HZ_TW-1:0] TNEW_LOAD = 3'd2;

    // One in-flight instruction as tracked through the post-decode stages.
    // Record widths follow the package defaults; REG_AW/TW overrides on the
    // top must match them.
    typedef struct packed {
        logic [HZ_REG_AW-1:0] dst;
        logic [HZ_TW-1:0]     tnew;
        logic [HZ_REG_AW-1:0] rsAddr;
        logic [HZ_REG_AW-1:0] rtAddr;
    } stageRec_t;

    // Remaining latency never goes below zero.
    function automatic logic [HZ_TW-1:0] satDec(input logic [HZ_TW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Nearest-producer lookup for one source operand across the tracked stages.
// Searches stages FIRST..STAGES; the smallest matching stage shadows older ones.
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int FIRST  = 1,
    parameter int REG_AW = HZ_REG_AW,
    parameter int TW     = HZ_TW,
    parameter int SW     = $clog2(STAGES + 1)
) (
    input  logic [REG_AW-1:0]     srcAddr,
    input  logic                  srcEn,
    input  logic [TW-1:0]         srcTuse,
    input  stageRec_t [STAGES:1]  recs,
    output logic [SW-1:0]         sel,
    output logic                  stall
);

    logic          hit;
    logic [SW-1:0] nearIdx;
    logic [TW-1:0] nearTnew;

    // Only dst/tnew take part in matching; address fields ride along.
    logic unusedRecBits;
    assign unusedRecBits = ^recs;

    // Walk from oldest to youngest so the nearest match is the last one kept.
    always_comb begin
        hit      = 1'b0;
        nearIdx  = '0;
        nearTnew = '0;
        for (int k = STAGES; k >= FIRST; k--) begin
            if (srcEn && (srcAddr != '0) && (recs[k].dst == srcAddr)) begin
                hit      = 1'b1;
                nearIdx  = SW'(k);
                nearTnew = recs[k].tnew;
            end
        end
    end

    // Stall if the nearest producer is later than the consumer needs it;
    // bypass only from a producer whose value already exists.
    always_comb begin
        stall = hit && (nearTnew > srcTuse);
        sel   = (hit && (nearTnew == '0)) ? nearIdx : SW'(SEL_GRF);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard: tracks in-flight destinations through STAGES
// post-decode stages, produces stall/flush, D/E bypass selects and a mul/div
// busy counter.
// Optional: define HAZ_PERF_CNT_EN to add stall_cycles / md_stall_cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW     = HZ_REG_AW,
    parameter int STAGES     = 3,
    parameter int TW         = HZ_TW,
    parameter int MD_LATENCY = 5,
    parameter int SW         = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic              id_rs_en,
    input  logic [TW-1:0]     id_rs_tuse,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              id_rt_en,
    input  logic [TW-1:0]     id_rt_tuse,
    input  logic [REG_AW-1:0] id_dst_addr,
    input  logic [TW-1:0]     id_tnew,
    input  logic              id_md,
    input  logic              id_md_start,
    output logic              pc_en,
    output logic              regd_en,
    output logic              rege_clear,
    output logic [SW-1:0]     fwd_d_rs_sel,
    output logic [SW-1:0]     fwd_d_rt_sel,
    output logic [SW-1:0]     fwd_e_rs_sel,
    output logic [SW-1:0]     fwd_e_rt_sel,
    output logic              md_busy
`ifdef HAZ_PERF_CNT_EN
   ,output logic [31:0]       stall_cycles,
    output logic [31:0]       md_stall_cycles
`endif
);

    stageRec_t [STAGES:1] rec;
    logic [TW-1:0]        mdCnt;
    logic                 mdStartPend;
    logic                 rsStall, rtStall, mdStall, stall;
    logic                 eRsStall, eRtStall;

    // D-stage lookups over every tracked stage.
    hazard_match #(.STAGES(STAGES), .FIRST(1), .REG_AW(REG_AW), .TW(TW), .SW(SW)) uMatchDRs (
        .srcAddr(id_rs_addr), .srcEn(id_rs_en), .srcTuse(id_rs_tuse),
        .recs(rec), .sel(fwd_d_rs_sel), .stall(rsStall)
    );
    hazard_match #(.STAGES(STAGES), .FIRST(1), .REG_AW(REG_AW), .TW(TW), .SW(SW)) uMatchDRt (
        .srcAddr(id_rt_addr), .srcEn(id_rt_en), .srcTuse(id_rt_tuse),
        .recs(rec), .sel(fwd_d_rt_sel), .stall(rtStall)
    );

    // E-stage lookups: the consumer sits in stage 1, so search from stage 2.
    // E operands carry no enable; address 0 alone suppresses the match.
    hazard_match #(.STAGES(STAGES), .FIRST(2), .REG_AW(REG_AW), .TW(TW), .SW(SW)) uMatchERs (
        .srcAddr(rec[1].rsAddr), .srcEn(1'b1), .srcTuse('0),
        .recs(rec), .sel(fwd_e_rs_sel), .stall(eRsStall)
    );
    hazard_match #(.STAGES(STAGES), .FIRST(2), .REG_AW(REG_AW), .TW(TW), .SW(SW)) uMatchERt (
        .srcAddr(rec[1].rtAddr), .srcEn(1'b1), .srcTuse('0),
        .recs(rec), .sel(fwd_e_rt_sel), .stall(eRtStall)
    );

    // A not-ready E operand is resolved later in the pipe, never by stalling here.
    logic unusedEStall;
    assign unusedEStall = eRsStall | eRtStall;

    // Stall/flush controls, all combinational from current state.
    always_comb begin
        mdStall    = id_md && (md_busy || mdStartPend);
        stall      = rsStall || rtStall || mdStall;
        pc_en      = ~stall;
        regd_en    = ~stall;
        rege_clear = stall;
        md_busy    = (mdCnt != '0);
    end

    // Stage records advance every cycle; a stall injects a bubble into E.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rec         <= '0;
            mdStartPend <= 1'b0;
        end else begin
            for (int k = STAGES; k >= 2; k--) begin
                rec[k] <= '{dst:    rec[k-1].dst,
                            tnew:   satDec(rec[k-1].tnew),
                            rsAddr: rec[k-1].rsAddr,
                            rtAddr: rec[k-1].rtAddr};
            end
            if (stall) begin
                rec[1]      <= '0;
                mdStartPend <= 1'b0;
            end else begin
                rec[1]      <= '{dst: id_dst_addr, tnew: id_tnew,
                                 rsAddr: id_rs_addr, rtAddr: id_rt_addr};
                mdStartPend <= id_md_start;
            end
        end
    end

    // Mul/div busy counter: a start that advances reloads, otherwise count down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdCnt <= '0;
        end else if (id_md_start && !stall) begin
            mdCnt <= TW'(MD_LATENCY);
        end else if (mdCnt != '0) begin
            mdCnt <= mdCnt - 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Free-running stall counters; they wrap at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles    <= '0;
            md_stall_cycles <= '0;
        end else begin
            if (stall)   stall_cycles    <= stall_cycles + 32'd1;
            if (mdStall) md_stall_cycles <= md_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the 5-stage Tuse/Tnew hazard unit. Decode supplies pre-decoded operand addresses, Tuse and Tnew, so the block never decodes opcodes itself.
- Tracks every in-flight destination through STAGES post-decode stages (stage 1 = E, stage STAGES = W).
- Remaining-latency counters decrement each cycle in place of a fixed stage-to-Tnew table.
- Generates stall/flush controls, D- and E-stage bypass selects, and an internal mul/div busy counter.

Parameters:
- REG_AW, 5, register address width; address 0 is hard-wired zero and never hazards.
- STAGES, 3, post-decode stages tracked (E, M, W); legal range 2..7.
- TW, 3, width of Tuse/Tnew fields.
- MD_LATENCY, 5, mul/div busy cycles after a start; legal range 1..2^TW-1.
- SW, $clog2(STAGES+1), width of bypass select.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- id_rs_addr  in  REG_AW  D-stage rs address
- id_rs_en  in  1  D instruction reads rs
- id_rs_tuse  in  TW  cycles until rs value is consumed (0 = at D)
- id_rt_addr  in  REG_AW  D-stage rt address
- id_rt_en  in  1  D instruction reads rt
- id_rt_tuse  in  TW  cycles until rt value is consumed
- id_dst_addr  in  REG_AW  destination address (0 = none)
- id_tnew  in  TW  cycles after entering E until the result exists
- id_md  in  1  D instruction uses the HI/LO/mul-div unit
- id_md_start  in  1  D instruction starts a mul/div
- pc_en  out  1  PC write enable
- regd_en  out  1  D pipeline-register enable
- rege_clear  out  1  insert bubble into E
- fwd_d_rs_sel  out  SW  D rs bypass: 0 = GRF, k = stage k
- fwd_d_rt_sel  out  SW  D rt bypass
- fwd_e_rs_sel  out  SW  E rs bypass: 0 = pipe value, k = stage k (k >= 2)
- fwd_e_rt_sel  out  SW  E rt bypass
- md_busy  out  1  mul/div counter nonzero

Behaviour:
- Stage record k (1..STAGES) holds: dst, tnew, rs_addr, rt_addr.
- Each clk: record k+1 <= record k, with tnew saturating-decremented (max(tnew-1, 0)).
- Record 1 <= D fields when no stall; when stall, record 1 <= all zero (bubble).
- Record 1 tnew loads id_tnew unmodified.
- Match on stage k for source s: dst_k == s, s != 0, and the source enable is set.
- Nearest match = smallest k among matches.
- Stall on source s when the nearest match has tnew_k > tuse_s. Only the nearest match is checked; older producers are shadowed.
- md stall when id_md && (md_busy || md_start_pend).
- stall = rs stall | rt stall | md stall.
- pc_en = regd_en = ~stall; rege_clear = stall. All are combinational from current state.
- D select = nearest match k if tnew_k == 0; 0 if there is no match or the nearest match is not ready. The not-ready case is legal only because no stall implies the value is re-bypassed at E.
- E select uses the same rule over stages 2..STAGES with stage-1 rs/rt addresses. E operands have no enable; address 0 gives 0.
- Mul/div counter:
  - Loads MD_LATENCY on the cycle an instruction with id_md_start advances, i.e. !stall.
  - Otherwise decrements to 0.
  - md_busy = counter != 0.
  - md_start_pend is record-1 start flag, covering the cycle in E before the load takes effect.
- Simultaneous load and decrement: load wins.
- Reset (asynchronous, active-low): all records and the counter clear immediately. Outputs then read pc_en=1, regd_en=1, rege_clear=0, all selects 0, md_busy=0.
- Reset mid-stall discards in-flight state; there is no replay.
- Two stages matching the same address: the nearest wins for both stall and bypass.

Optional Feature:
- HAZ_PERF_CNT_EN: adds output stall_cycles [31:0] and output md_stall_cycles [31:0].
  - Each counter increments on every clk where its stall term is 1.
  - Each counter wraps at 2^32 and clears on reset.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - stage-record typedef {dst, tnew, rs_addr, rt_addr};
  - constant SEL_GRF = 0;
  - TW/REG_AW defaults;
  - Tnew/Tuse encodings used by the decoder.
- One sub-module: hazard_match. It is combinational, instantiated once per source; it takes a source address plus the STAGES records and returns the nearest-match index and ready/stall flags.

Test Plan:
- Load-use: lw $2 (tnew=2) in E, D add reads $2 with tuse=1 → stall for 1 cycle, rege_clear=1. Next cycle fwd_e_rs_sel=0, and at W, fwd_e_rs_sel=3.
- ALU to branch: addu $3 (tnew=1) in E, D beq $3 with tuse=0 → 1 stall. Then fwd_d_rs_sel=2 (M, tnew=0).
- Shadowing: ori $4 in M (ready) and lw $4 in E (tnew=2), D reads $4 with tuse=1 → stall. Select never points to M.
- $0 and disabled source: dst=0 producers, and id_rs_en=0 with a matching address → no stall, selects 0.
- Mul/div: mult advances at t0 → md_busy is 1 from t1 for 5 cycles. mfhi in D stalls through t5 (md_start_pend covers t0+1) and issues at t6. An id_md=0 instruction issues without stall.
- Async reset asserted mid-stall → pc_en=1 and md_busy=0 immediately, without waiting for a clock edge. With HAZ_PERF_CNT_EN, stall_cycles is 0 after reset and equals the stall count of the preceding scenarios.
